// File: rtl/vedic_mac_sequencer_pkg.sv
// Shared types and width helpers for the vedic MAC tap sequencer.
package vedic_mac_sequencer_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int TAPS_DEF = 8;
   localparam int DW_DEF   = 8;

   // Wide enough for TAPS full-scale products summed without overflow.
   function automatic int acc_width(input int dw, input int aw);
      return 2 * dw + aw;
   endfunction
endpackage

// File: rtl/vedic_mac_sequencer_if.sv
// Request/config/result bundle between the sample source, LMS update logic and the tap engine.
interface vedic_mac_sequencer_if
   import vedic_mac_sequencer_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int AW   = $clog2(TAPS_DEF),
   parameter int ACCW = acc_width(DW, AW)
);
   logic            start;
   logic [DW-1:0]   sample_in;
   logic            coef_we;
   logic [AW-1:0]   coef_addr;
   logic [DW-1:0]   coef_wdata;
   logic            busy;
   logic            done;
   logic [ACCW-1:0] y_out;

   modport master (
      output start, sample_in, coef_we, coef_addr, coef_wdata,
      input  busy, done, y_out
   );

   modport slave (
      input  start, sample_in, coef_we, coef_addr, coef_wdata,
      output busy, done, y_out
   );
endinterface

// File: rtl/vedic_mac_sequencer_vedic_8x8.sv
// Unsigned 8x8 multiplier, combinational, built from four 4x4 vertical/crosswise partial products.
module vedic_8x8 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);
   logic [7:0] ll, lh, hl, hh;
   logic [8:0] mid;

   assign ll  = a[3:0] * b[3:0];
   assign lh  = a[3:0] * b[7:4];
   assign hl  = a[7:4] * b[3:0];
   assign hh  = a[7:4] * b[7:4];
   assign mid = {1'b0, lh} + {1'b0, hl};
   assign p   = {hh, 8'h00} + {3'b000, mid, 4'h0} + {8'h00, ll};
endmodule

// File: rtl/vedic_mac_sequencer.sv
// FIR/LMS tap engine: one shared 8x8 multiplier sequenced over TAPS taps per start.
// done pulses TAPS+1 cycles after the accepted start; start and coef writes are ignored while busy.
module vedic_mac_sequencer
   import vedic_mac_sequencer_pkg::*;
#(
   parameter int TAPS = TAPS_DEF,
   parameter int DW   = DW_DEF,
   parameter int AW   = $clog2(TAPS),
   parameter int ACCW = acc_width(DW, AW)
) (
   input  logic                  clk,
   input  logic                  rst,
   vedic_mac_sequencer_if.slave  bus
);
   state_t          state, state_nxt;
   logic [DW-1:0]   x [TAPS];
   logic [DW-1:0]   c [TAPS];
   logic [AW-1:0]   k;
   logic [2*DW-1:0] prod, prod_r;
   logic [ACCW-1:0] acc, y_r;
   logic            busy_r, done_r;
   logic            last_tap;

   assign last_tap  = (k == AW'(TAPS - 1));
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.y_out = y_r;

   vedic_8x8 u_mul (
      .a (x[k]),
      .b (c[k]),
      .p (prod)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = MUL;
         MUL:     if (last_tap)  state_nxt = DRAIN;
         DRAIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TAPS; i++) begin
            x[i] <= '0;
            c[i] <= '0;
         end
         k      <= '0;
         acc    <= '0;
         prod_r <= '0;
         y_r    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         // Coefficients only change between computations, including the start edge itself.
         if (state == IDLE && bus.coef_we) c[bus.coef_addr] <= bus.coef_wdata;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  x[0] <= bus.sample_in;
                  for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
                  acc    <= '0;
                  k      <= '0;
                  busy_r <= 1'b1;
               end
            end
            MUL: begin
               prod_r <= prod;
               k      <= k + 1'b1;
               // prod_r is stale on the first MUL edge, so accumulation starts one tap late.
               if (k != '0) acc <= acc + ACCW'(prod_r);
            end
            DRAIN: begin
               y_r    <= acc + ACCW'(prod_r);
               done_r <= 1'b1;
               busy_r <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_vedic_mac_sequencer.sv
// Directed bench with a reference model and scoreboard for vedic_mac_sequencer.
module tb_vedic_mac_sequencer;
   import vedic_mac_sequencer_pkg::*;

   localparam int TAPS = 8;
   localparam int DW   = 8;
   localparam int AW   = 3;
   localparam int ACCW = 19;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vedic_mac_sequencer_if #(.DW(DW), .AW(AW), .ACCW(ACCW)) bus ();

   vedic_mac_sequencer #(.TAPS(TAPS), .DW(DW), .AW(AW), .ACCW(ACCW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         checks = 0;
   int         passes = 0;
   int         m_left;
   logic [7:0] mx [TAPS];
   logic [7:0] mc [TAPS];
   int         q [$];
   int         done_cnt, busy_cnt, exp_done_cnt;
   logic       exp_done;
   int         n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int model_sum();
      int s = 0;
      for (int i = 0; i < TAPS; i++) s += int'(mx[i]) * int'(mc[i]);
      return s;
   endfunction

   // Advance one clock: update the reference model for this edge, then check the DUT.
   task automatic step();
      exp_done = 1'b0;
      if (rst) begin
         for (int i = 0; i < TAPS; i++) begin
            mx[i] = '0;
            mc[i] = '0;
         end
         m_left = 0;
         q.delete();
      end else if (m_left == 0) begin
         if (bus.coef_we) mc[bus.coef_addr] = bus.coef_wdata;
         if (bus.start) begin
            for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
            mx[0] = bus.sample_in;
            q.push_back(model_sum());
            m_left = TAPS + 1;
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            exp_done = 1'b1;
            exp_done_cnt++;
         end
      end
      @(posedge clk);
      #1;
      chk("busy", bus.busy, m_left != 0);
      chk("done", bus.done, exp_done);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
         done_cnt++;
         chk("sb_depth_at_done", q.size(), 1);
         if (q.size() > 0) chk("y_out_sb", bus.y_out, q.pop_front());
      end
   endtask

   task automatic write_coef(input int a, input int d);
      bus.coef_we    = 1'b1;
      bus.coef_addr  = AW'(a);
      bus.coef_wdata = DW'(d);
      step();
      bus.coef_we    = 1'b0;
   endtask

   task automatic start_op(input int s);
      bus.start     = 1'b1;
      bus.sample_in = DW'(s);
      step();
      bus.start     = 1'b0;
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!bus.done && cnt < 60);
   endtask

   initial begin
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.sample_in  = '0;
      bus.coef_we    = 1'b0;
      bus.coef_addr  = '0;
      bus.coef_wdata = '0;
      m_left         = 0;
      done_cnt       = 0;
      busy_cnt       = 0;
      exp_done_cnt   = 0;
      for (int i = 0; i < TAPS; i++) begin
         mx[i] = '0;
         mc[i] = '0;
      end
      step();
      step();
      rst = 1'b0;
      chk("reset_y_out", bus.y_out, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);

      // Single tap, latency and busy width
      write_coef(0, 2);
      busy_cnt = 0;
      start_op(3);
      wait_done(n);
      chk("t1_latency", n, TAPS + 1);
      chk("t1_y", bus.y_out, 6);
      chk("t1_busy_cycles", busy_cnt, TAPS + 1);

      write_coef(0, 'h3D);
      start_op('hDD);
      wait_done(n);
      chk("t2_y", bus.y_out, 'h34A9);

      // Full scale, back-to-back starts in the done cycle
      for (int i = 0; i < TAPS; i++) write_coef(i, 255);
      done_cnt = 0;
      for (int i = 0; i < TAPS; i++) begin
         start_op(255);
         wait_done(n);
      end
      chk("t3_y_full_scale", bus.y_out, 520200);
      chk("t3_done_cnt", done_cnt, TAPS);

      // start and coef write while busy are ignored
      done_cnt = 0;
      start_op(1);
      step();
      step();
      bus.start      = 1'b1;
      bus.sample_in  = 8'd7;
      bus.coef_we    = 1'b1;
      bus.coef_addr  = '0;
      bus.coef_wdata = 8'd9;
      step();
      bus.start      = 1'b0;
      bus.coef_we    = 1'b0;
      wait_done(n);
      repeat (4) step();
      chk("t4_y", bus.y_out, 455430);
      chk("t4_done_cnt", done_cnt, 1);
      start_op(2);
      wait_done(n);
      chk("t4_next_y", bus.y_out, 390915);

      // Reset mid-computation
      start_op(4);
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_busy_after_rst", bus.busy, 0);
      chk("t5_y_after_rst", bus.y_out, 0);
      done_cnt = 0;
      repeat (12) step();
      chk("t5_no_done", done_cnt, 0);
      write_coef(0, 1);
      start_op(5);
      wait_done(n);
      chk("t5_y", bus.y_out, 5);

      // start held high continuously
      for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
      done_cnt     = 0;
      exp_done_cnt = 0;
      bus.start    = 1'b1;
      for (int i = 0; i < 45; i++) begin
         bus.sample_in = DW'(i + 10);
         step();
      end
      bus.start = 1'b0;
      repeat (12) step();
      chk("t6_done_cnt", done_cnt, exp_done_cnt);
      chk("sb_empty", q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
